oled_screen_arbiter: RTL and testbench

OLED_SCREEN_ARBITER -- requirements
Module: oled_screen_arbiter

---
 rtl/oled_screen_arbiter.sv | 136 +++++++++++++
 tb/tb_oled_screen_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/oled_screen_arbiter.sv
// Selects which screen source drives the OLED and sequences menu/board/game-over with blank gaps.
// Latency: pixel_data is registered 1 cycle after the state; screen/board_active change with the state.
// Backpressure: none; requests are latched as sticky flags and committed only on frame_begin.
module oled_screen_arbiter #(
    parameter int unsigned BLANK_FRAMES     = 2,
    parameter int unsigned OVER_HOLD_FRAMES = 60,
    parameter logic [15:0] BLANK_COLOUR     = 16'h0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_begin,
    input  logic [12:0] pixel_index,
    input  logic        start_req,
    input  logic        game_over,
    input  logic        abort,
    input  logic [15:0] menu_pixel,
    input  logic [15:0] board_pixel,
    input  logic [15:0] over_pixel,
    output logic [15:0] pixel_data,
    output logic [1:0]  screen,
    output logic        board_active,
    output logic [7:0]  frame_count
);

    typedef enum logic [1:0] {
        S_MENU  = 2'd0,
        S_BLANK = 2'd1,
        S_BOARD = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_FRAMES - 1);
    localparam logic [7:0] OVER_LOAD  = 8'(OVER_HOLD_FRAMES - 1);

    state_t     state, target;
    state_t     nxt_state, nxt_target;
    logic [7:0] cnt, nxt_cnt;
    logic       pend_start, pend_over, pend_abort;
    logic       eff_start, eff_over, eff_abort;
    logic       state_change;

    // The pixel index is consumed by the screen sources, not by the mux.
    logic unused_pixel_index;
    assign unused_pixel_index = ^pixel_index;

    assign eff_start = pend_start | start_req;
    assign eff_over  = pend_over  | game_over;
    assign eff_abort = pend_abort | abort;

    always_comb begin
        nxt_state  = state;
        nxt_target = target;
        nxt_cnt    = cnt;
        if (frame_begin) begin
            unique case (state)
                S_MENU: begin
                    if (eff_start) begin
                        nxt_state  = S_BLANK;
                        nxt_target = S_BOARD;
                        nxt_cnt    = BLANK_LOAD;
                    end
                end
                S_BOARD: begin
                    if (eff_abort) begin
                        nxt_state  = S_BLANK;
                        nxt_target = S_MENU;
                        nxt_cnt    = BLANK_LOAD;
                    end else if (eff_over) begin
                        nxt_state = S_OVER;
                        nxt_cnt   = OVER_LOAD;
                    end
                end
                S_OVER: begin
                    if (eff_abort || cnt == 8'd0) begin
                        nxt_state  = S_BLANK;
                        nxt_target = S_MENU;
                        nxt_cnt    = BLANK_LOAD;
                    end else begin
                        nxt_cnt = cnt - 8'd1;
                    end
                end
                S_BLANK: begin
                    // Requests are deliberately ignored while blanking.
                    if (cnt == 8'd0) begin
                        nxt_state = target;
                    end else begin
                        nxt_cnt = cnt - 8'd1;
                    end
                end
                default: nxt_state = S_MENU;
            endcase
        end
    end

    assign state_change = (nxt_state != state);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_MENU;
            target       <= S_MENU;
            cnt          <= 8'd0;
            pend_start   <= 1'b0;
            pend_over    <= 1'b0;
            pend_abort   <= 1'b0;
            pixel_data   <= 16'h0000;
            screen       <= 2'd0;
            board_active <= 1'b0;
            frame_count  <= 8'd0;
        end else begin
            state        <= nxt_state;
            target       <= nxt_target;
            cnt          <= nxt_cnt;
            screen       <= nxt_state;
            board_active <= nxt_state[1];
            if (frame_begin) begin
                frame_count <= frame_count + 8'd1;
            end
            if (state_change) begin
                pend_start <= 1'b0;
                pend_over  <= 1'b0;
                pend_abort <= 1'b0;
            end else begin
                pend_start <= pend_start | (start_req && state == S_MENU);
                pend_over  <= pend_over  | (game_over && state == S_BOARD);
                pend_abort <= pend_abort | (abort && (state == S_BOARD || state == S_OVER));
            end
            unique case (state)
                S_MENU:  pixel_data <= menu_pixel;
                S_BLANK: pixel_data <= BLANK_COLOUR;
                S_BOARD: pixel_data <= board_pixel;
                default: pixel_data <= over_pixel;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_screen_arbiter.sv
// Directed and randomized bench for oled_screen_arbiter against a frame-level screen model.
module tb_oled_screen_arbiter;

    localparam int BF = 2;
    localparam int OH = 60;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_begin = 1'b0;
    logic [12:0] pixel_index = '0;
    logic        start_req = 1'b0;
    logic        game_over = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] menu_pixel = '0;
    logic [15:0] board_pixel = '0;
    logic [15:0] over_pixel = '0;
    logic [15:0] pixel_data;
    logic [1:0]  screen;
    logic        board_active;
    logic [7:0]  frame_count;

    always #5 clk = ~clk;

    oled_screen_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .frame_begin  (frame_begin),
        .pixel_index  (pixel_index),
        .start_req    (start_req),
        .game_over    (game_over),
        .abort        (abort),
        .menu_pixel   (menu_pixel),
        .board_pixel  (board_pixel),
        .over_pixel   (over_pixel),
        .pixel_data   (pixel_data),
        .screen       (screen),
        .board_active (board_active),
        .frame_count  (frame_count)
    );

    int errors = 0;
    int checks = 0;
    bit fix_menu = 1'b0;

    // Model: screen id, where BLANK goes next, whole frames left, pending requests.
    int          m_scr, m_target, m_left, m_fc;
    bit          m_ps, m_po, m_pa;
    logic [15:0] m_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scr = 0; m_target = 0; m_left = 0; m_fc = 0;
        m_ps = 0; m_po = 0; m_pa = 0; m_pix = 16'h0000;
    endtask

    task automatic enter_blank(input int tgt, inout int nscr);
        nscr = 1; m_target = tgt; m_left = BF;
    endtask

    task automatic model_edge();
        int nscr;
        logic [15:0] p;
        if (!resetn) begin
            model_reset();
            return;
        end
        p = (m_scr == 0) ? menu_pixel : (m_scr == 1) ? 16'h0000 :
            (m_scr == 2) ? board_pixel : over_pixel;
        nscr = m_scr;
        if (frame_begin) begin
            m_fc = (m_fc + 1) % 256;
            if (m_scr == 0 && (m_ps || start_req)) enter_blank(2, nscr);
            else if (m_scr == 2 && (m_pa || abort)) enter_blank(0, nscr);
            else if (m_scr == 2 && (m_po || game_over)) begin
                nscr = 3; m_left = OH;
            end else if (m_scr == 3 && (m_pa || abort)) enter_blank(0, nscr);
            else if (m_scr == 1 || m_scr == 3) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_scr == 3) enter_blank(0, nscr);
                    else nscr = m_target;
                end
            end
        end
        if (nscr != m_scr) begin
            m_ps = 0; m_po = 0; m_pa = 0;
        end else begin
            if (m_scr == 0 && start_req) m_ps = 1;
            if (m_scr == 2 && game_over) m_po = 1;
            if (m_scr >= 2 && abort) m_pa = 1;
        end
        m_scr = nscr;
        m_pix = p;
    endtask

    task automatic compare_all();
        check("screen", screen, m_scr);
        check("board_active", board_active, (m_scr >= 2) ? 1 : 0);
        check("pixel_data", pixel_data, m_pix);
        check("frame_count", frame_count, m_fc);
    endtask

    task automatic cyc(input bit fb, input bit sr, input bit go, input bit ab);
        frame_begin = fb; start_req = sr; game_over = go; abort = ab;
        menu_pixel  = fix_menu ? 16'hF800 : 16'($urandom);
        board_pixel = 16'($urandom);
        over_pixel  = 16'($urandom);
        pixel_index = 13'($urandom_range(0, 6143));
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // One frame of len cycles; each request pulses at its position (-1 = never).
    task automatic frame(input int len, input int p_sr, input int p_go, input int p_ab);
        for (int i = 0; i < len; i++) cyc(i == 0, i == p_sr, i == p_go, i == p_ab);
    endtask

    initial begin
        model_reset();
        resetn = 1'b0;
        repeat (3) cyc(0, 0, 0, 0);
        resetn = 1'b1;
        check("rst_screen", screen, 0);
        check("rst_pixel", pixel_data, 0);

        // Start sequence
        fix_menu = 1'b1;
        repeat (2) frame(6, -1, -1, -1);
        frame(6, 3, -1, -1);
        check("menu_colour", pixel_data, 16'hF800);
        fix_menu = 1'b0;
        repeat (3) frame(6, -1, -1, -1);
        check("start_board_active", board_active, 1);

        // start_req is dropped in BOARD
        frame(6, 2, -1, -1);
        frame(6, -1, -1, -1);
        check("start_in_board", screen, 2);

        // Game over: OVER, BLANK, back to MENU
        frame(5, -1, 1, -1);
        repeat (63) frame(4, -1, -1, -1);
        check("over_done_screen", screen, 0);
        check("over_done_active", board_active, 0);

        // Same-cycle request
        cyc(1, 1, 0, 0);
        check("same_cycle", screen, 1);
        repeat (3) cyc(0, 0, 0, 0);
        repeat (2) frame(4, -1, -1, -1);
        check("same_cycle_board", screen, 2);

        // abort beats game_over
        frame(6, -1, 1, 3);
        frame(6, -1, -1, -1);
        check("prio_blank", screen, 1);
        repeat (2) frame(6, -1, -1, -1);
        check("prio_menu", screen, 0);

        // Reset in the middle of OVER
        frame(4, 1, -1, -1);
        repeat (2) frame(4, -1, -1, -1);
        frame(4, -1, 2, -1);
        repeat (30) frame(4, -1, -1, -1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("pre_reset_over", screen, 3);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) cyc(1, 0, 0, 0);
        resetn = 1'b1;
        cyc(0, 0, 0, 0);
        repeat (256) frame(3, -1, -1, -1);
        check("fc_wrap", frame_count, 0);
        check("post_reset_screen", screen, 0);

        // Randomized traffic
        for (int f = 0; f < 400; f++) begin
            int len;
            len = $urandom_range(3, 7);
            frame(len,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
